// File: rtl/mem_pkg_v.sv
// Shared constants for the memory-access stage: funct3 access codes and FSM encodings.
package mem_pkg_v;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    WAIT_RD = 1'b1
  } mem_state_e;

endpackage

// File: rtl/load_ext_v.sv
// Load formatter: selects the addressed byte/half from a load word and sign- or zero-extends it.
module load_ext_v
  import mem_pkg_v::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    ext = rdata;
    case (funct3)
      F3_B:    ext = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   ext = {24'h0, byte_sel};
      F3_H:    ext = {{16{half_sel[15]}}, half_sel};
      F3_HU:   ext = {16'h0, half_sel};
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_v.sv
// Pipeline memory stage: issues data-memory requests, formats store lanes and load results,
// and stalls the front of the pipe while a load is outstanding.
module mem_stage_v
  import mem_pkg_v::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_isValid,
  input  logic [31:0]       ex_pc,
  input  logic [31:0]       ex_instr,
  input  logic [4:0]        ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_reg_write,
  input  logic [2:0]        ex_funct3,
  input  logic [31:0]       ex_aluResult,
  input  logic [31:0]       ex_storeData,
  output logic              mem_isValid,
  output logic [31:0]       mem_pc,
  output logic [31:0]       mem_instr,
  output logic [4:0]        mem_rd,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic              mem_reg_write,
  output logic [31:0]       mem_aluResult,
  output logic [31:0]       mem_memResult,
  output logic              mem_fault,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata
);

  mem_state_e state, state_next;

  logic [31:0] cap_pc, cap_instr, cap_alu;
  logic [4:0]  cap_rd;
  logic        cap_mem_read, cap_mem_write, cap_reg_write;
  logic [2:0]  cap_funct3;
  logic [1:0]  cap_addr_lo;

  logic [1:0]  addr_lo;
  logic        is_mem, is_load, is_store;
  logic        f3_ok, align_ok, legal, fault, issue;
  logic [31:0] load_val;

  assign addr_lo  = ex_aluResult[1:0];
  assign is_mem   = ex_mem_read | ex_mem_write;
  assign is_load  = ex_mem_read & ~ex_mem_write;
  assign is_store = ex_mem_write & ~ex_mem_read;

  always_comb begin
    f3_ok = 1'b0;
    if (is_load)
      f3_ok = (ex_funct3 == F3_B) || (ex_funct3 == F3_H) || (ex_funct3 == F3_W) ||
              (ex_funct3 == F3_BU) || (ex_funct3 == F3_HU);
    else if (is_store)
      f3_ok = (ex_funct3 == F3_B) || (ex_funct3 == F3_H) || (ex_funct3 == F3_W);
    // Size comes from funct3[1:0] so LHU shares the halfword alignment rule with LH.
    case (ex_funct3[1:0])
      2'b01:   align_ok = ~addr_lo[0];
      2'b10:   align_ok = (addr_lo == 2'b00);
      default: align_ok = 1'b1;
    endcase
  end

  assign legal = f3_ok & align_ok;
  assign fault = ex_isValid & is_mem & ~legal;
  assign issue = ex_isValid & is_mem & legal;

  always_comb begin
    dmem_addr  = {ex_aluResult[ADDR_W-1:2], 2'b00};
    dmem_be    = 4'b1111;
    dmem_wdata = ex_storeData;
    if (is_store) begin
      case (ex_funct3)
        F3_B: begin
          dmem_be    = 4'b0001 << addr_lo;
          dmem_wdata = {4{ex_storeData[7:0]}};
        end
        F3_H: begin
          dmem_be    = 4'b0011 << addr_lo;
          dmem_wdata = {2{ex_storeData[15:0]}};
        end
        default: begin
          dmem_be    = 4'b1111;
          dmem_wdata = ex_storeData;
        end
      endcase
    end
  end

  load_ext_v u_load_ext (
    .rdata  (dmem_rdata),
    .addr   (cap_addr_lo),
    .funct3 (cap_funct3),
    .ext    (load_val)
  );

  always_comb begin
    state_next    = state;
    mem_isValid   = 1'b0;
    mem_pc        = ex_pc;
    mem_instr     = ex_instr;
    mem_rd        = ex_rd;
    mem_mem_read  = ex_mem_read;
    mem_mem_write = ex_mem_write;
    mem_reg_write = ex_reg_write;
    mem_aluResult = ex_aluResult;
    mem_memResult = 32'h0;
    mem_fault     = 1'b0;
    stall         = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (ex_isValid && !is_mem) begin
            mem_isValid = 1'b1;
          end else if (fault) begin
            mem_isValid   = 1'b1;
            mem_fault     = 1'b1;
            mem_reg_write = 1'b0;
          end else if (issue) begin
            dmem_req = 1'b1;
            dmem_we  = is_store;
            if (!dmem_gnt) begin
              stall = 1'b1;
            end else if (is_store) begin
              mem_isValid = 1'b1;
            end else begin
              stall      = 1'b1;
              state_next = WAIT_RD;
            end
          end
        end
        WAIT_RD: begin
          mem_pc        = cap_pc;
          mem_instr     = cap_instr;
          mem_rd        = cap_rd;
          mem_mem_read  = cap_mem_read;
          mem_mem_write = cap_mem_write;
          mem_reg_write = cap_reg_write;
          mem_aluResult = cap_alu;
          if (dmem_rvalid) begin
            mem_isValid   = 1'b1;
            mem_memResult = load_val;
            state_next    = IDLE;
          end else begin
            stall = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cap_pc        <= '0;
      cap_instr     <= '0;
      cap_alu       <= '0;
      cap_rd        <= '0;
      cap_mem_read  <= 1'b0;
      cap_mem_write <= 1'b0;
      cap_reg_write <= 1'b0;
      cap_funct3    <= '0;
      cap_addr_lo   <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && issue && is_load && dmem_gnt) begin
        cap_pc        <= ex_pc;
        cap_instr     <= ex_instr;
        cap_alu       <= ex_aluResult;
        cap_rd        <= ex_rd;
        cap_mem_read  <= ex_mem_read;
        cap_mem_write <= ex_mem_write;
        cap_reg_write <= ex_reg_write;
        cap_funct3    <= ex_funct3;
        cap_addr_lo   <= addr_lo;
      end
    end
  end

endmodule

// File: doc/mem_stage_v.md
Name: mem_stage_v

Overview:
Memory-access stage of the 5-stage pipeline. It sits between the EX/MEM register and the MEM/WB register, and produces the mem_* bundle that the MEM/WB register latches whenever mem_isValid=1. It drives a request/grant/rvalid data-memory port, formats store byte lanes and load sign/zero extension, and stalls the front of the pipe while an access is outstanding.

Parameters:
ADDR_W, 32, data-memory byte-address width (ex_aluResult[ADDR_W-1:0] used)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ex_isValid  in  1  EX/MEM slot holds a live instruction
ex_pc, ex_instr  in  32 each  passed through
ex_rd  in  5  passed through
ex_mem_read, ex_mem_write, ex_reg_write  in  1 each  control bits
ex_funct3  in  3  access size/sign
ex_aluResult  in  32  effective address or ALU result
ex_storeData  in  32  rs2 value for stores
mem_isValid  out  1  result valid this cycle (MEM/WB capture strobe)
mem_pc, mem_instr  out  32 each
mem_rd  out  5
mem_mem_read, mem_mem_write, mem_reg_write  out  1 each
mem_aluResult, mem_memResult  out  32 each
mem_fault  out  1  misaligned/illegal access, 1-cycle pulse
stall  out  1  hold EX/MEM and all earlier stages
dmem_req  out  1  access request
dmem_we  out  1  1=store
dmem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-shifted store data
dmem_gnt  in  1  request accepted this cycle
dmem_rvalid  in  1  load data valid
dmem_rdata  in  32  load word

Behaviour:
- Synchronous, active-high reset. While reset is high, state=IDLE and all capture registers are 0. Outputs during reset: mem_isValid=0, stall=0, dmem_req=0, mem_fault=0.
- FSM has two states: IDLE and WAIT_RD. Upstream holds ex_* stable while stall=1.
- IDLE, ex_isValid=0: no request, mem_isValid=0, stall=0.
- IDLE, valid non-memory op (read=write=0): combinational pass-through.
  - mem_isValid=1 in the same cycle, mem_memResult=0.
- IDLE, valid access that passes the checks: dmem_req=1 with addr/be/we/wdata driven.
  - gnt=0: stall=1, remain IDLE.
  - Store with gnt=1: mem_isValid=1 that cycle, stall=0.
  - Load with gnt=1: capture pc/instr/rd/ctrl/aluResult/funct3/addr[1:0], go to WAIT_RD, stall=1.
- WAIT_RD: dmem_req=0 and stall=1 until dmem_rvalid.
  - On rvalid: mem_isValid=1, outputs come from the captured fields, mem_memResult = extended rdata, stall=0, go to IDLE.
- Alignment checks:
  - Halfword requires addr[0]=0.
  - Word requires addr[1:0]=0.
  - funct3 must be in {000,001,010,100,101} for loads and {000,001,010} for stores.
  - ex_mem_read=ex_mem_write=1 is illegal.
- On a failed check: no request, mem_isValid=1, mem_fault=1, mem_reg_write=0, stall=0.
- Store lanes:
  - SB: be = 0001<<addr[1:0], wdata = {4{byte}}.
  - SH: be = 0011<<addr[1:0], wdata = {2{half}}.
  - SW: be=1111.
- Loads: dmem_be=1111. The byte/half is selected by the captured addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
- dmem_rvalid in IDLE is ignored. This covers a response orphaned by reset during WAIT_RD.
- Reset during WAIT_RD drops the load. No mem_isValid is produced for it.
- At most one outstanding load. dmem_rvalid is never expected in the same cycle as gnt.

Decomposition:
- Shared package mem_pkg_v: funct3 constants (F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101) and state encodings.
- One sub-module, load_ext_v (combinational): inputs rdata, addr[1:0], funct3; output the 32-bit extended value.

Test Plan:
- Non-memory: ex_isValid=1, ADD, aluResult=0x0000_0042, rd=5, reg_write=1 -> same cycle mem_isValid=1, mem_aluResult=0x42, mem_rd=5, stall=0, dmem_req=0.
- SB: addr=0x1003, storeData=0x0000_00AB, gnt=1 -> dmem_addr=0x1000, be=1000, wdata=0xABABABAB, mem_isValid=1 same cycle.
- LB with gnt delayed 2 cycles, rvalid 3 cycles after gnt:
  - addr=0x2001, rdata=0x1234_80FF.
  - Expect stall=1 for 5 cycles, dmem_req high only until gnt.
  - Expect one mem_isValid with memResult=0xFFFF_FF80.
- LHU at addr=0x2002, rdata=0x8001_0000 -> memResult=0x0000_8001. LH at the same address -> 0xFFFF_8001.
- Misaligned LW: addr=0x3002 -> no dmem_req, mem_isValid=1, mem_fault=1, mem_reg_write=0, stall=0.
- Reset during WAIT_RD, then rvalid the cycle after reset deasserts -> no mem_isValid, state IDLE, stall=0. The next ADD passes normally.
